// File: rtl/data_memory_responder.sv
// Word-addressed data memory answering one load/store at a time over valid/ready channels.
// Response latency is set by LATENCY; contents reload from initial_values on reset.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    input  logic [31:0] initial_values [0:DEPTH_WORDS-1],
    output logic [31:0] memory_check   [0:DEPTH_WORDS-1]
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [29:0]      DEPTH_LIM = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count_p0;
    logic              write_p0;
    logic [31:0]       addr_p0;
    logic [31:0]       wdata_p0;
    logic [3:0]        wstrb_p0;
    logic [31:0]       mem [0:DEPTH_WORDS-1];
    logic              accept;
    logic              access;
    logic              error_p0;
    logic [IDX_W-1:0]  index_p0;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    assign accept   = req_valid && req_ready;
    assign access   = (state == WAIT) && (count_p0 == '0);
    assign error_p0 = (addr_p0[1:0] != 2'b00) || (addr_p0[31:2] >= DEPTH_LIM);
    assign index_p0 = addr_p0[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = WAIT;
            end
            WAIT: begin
                if (count_p0 == '0) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: request latched at acceptance, held through WAIT
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0 <= req_write;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            wstrb_p0 <= req_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                              count_p0 <= '0;
        else if (accept)                        count_p0 <= CNT_LOAD;
        else if (state == WAIT && count_p0 != '0) count_p0 <= count_p0 - 1'b1;
    end

    // Response registers: loaded on the access edge, cleared on handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else if (access) begin
            resp_rdata <= (!error_p0 && !write_p0) ? mem[index_p0] : 32'h0;
            resp_error <= error_p0;
        end else if (resp_valid && resp_ready) begin
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= initial_values[i];
        end else if (access && write_p0 && !error_p0) begin
            mem[index_p0] <= merge_bytes(mem[index_p0], wdata_p0, wstrb_p0);
        end
    end

    assign memory_check = mem;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a LATENCY=2 instance driven from a vector table plus
// corner sequences, and a LATENCY=1 instance run back-to-back with resp_ready tied high.
module tb_data_memory_responder;

    localparam int DEPTH = 32;
    localparam int LAT_A = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] init_vals [0:DEPTH-1];

    logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_error;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [3:0]  a_req_wstrb;
    logic [31:0] a_mem [0:DEPTH-1];

    logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_error;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_wstrb;
    logic [31:0] b_mem [0:DEPTH-1];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    vec_t        vecs [12];
    resp_t       sb_a [$];
    resp_t       sb_b [$];
    logic [31:0] exp_mem [0:DEPTH-1];

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_error(a_resp_error),
        .initial_values(init_vals), .memory_check(a_mem)
    );

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_error(b_resp_error),
        .initial_values(init_vals), .memory_check(b_mem)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic a_txn(input vec_t v, input int hold);
        resp_t e;
        int    k;
        logic  seen;
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_write = v.wr;
        a_req_addr  = v.addr;
        a_req_wdata = v.wdata;
        a_req_wstrb = v.wstrb;
        check("req_ready_idle", 32'(a_req_ready), 32'd1);
        @(posedge clk);
        e.rdata = v.rdata;
        e.err   = v.err;
        sb_a.push_back(e);
        #1;
        a_req_valid = 1'b0;
        a_req_write = ~v.wr;
        a_req_addr  = $urandom;
        a_req_wdata = $urandom;
        a_req_wstrb = 4'hF;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (a_resp_valid) seen = 1'b1;
            else check("req_ready_wait", 32'(a_req_ready), 32'd0);
        end
        check("resp_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check("latency", 32'(k), 32'(LAT_A + 1));
        e = sb_a.pop_front();
        check("resp_rdata", a_resp_rdata, e.rdata);
        check("resp_error", 32'(a_resp_error), 32'(e.err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(a_resp_valid), 32'd1);
            check("hold_rdata", a_resp_rdata, e.rdata);
            check("hold_req_ready", 32'(a_req_ready), 32'd0);
        end
        a_resp_ready = 1'b1;
        @(posedge clk);
        #1 a_resp_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 32'(a_resp_valid), 32'd0);
        check("post_req_ready", 32'(a_req_ready), 32'd1);
        check("post_rdata", a_resp_rdata, 32'd0);
        check("post_error", 32'(a_resp_error), 32'd0);
    endtask

    initial begin
        int    n, last_acc, acc_cnt, resp_cnt;
        logic  pending, stray;
        resp_t e;

        for (int i = 0; i < DEPTH; i++) begin
            init_vals[i] = 32'(i * 16);
            exp_mem[i]   = 32'(i * 16);
        end
        vecs[0]  = '{1'b0, 32'h0000000C, 32'h0, 4'h0, 32'h00000030, 1'b0};
        vecs[1]  = '{1'b1, 32'h00000008, 32'hDEADBEEF, 4'b0101, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 32'h00000008, 32'h0, 4'h0, 32'h00AD00EF, 1'b0};
        vecs[3]  = '{1'b0, 32'h00000006, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[4]  = '{1'b1, 32'h00000080, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1};
        vecs[5]  = '{1'b1, 32'h00000010, 32'h11111111, 4'h0, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h00000010, 32'h0, 4'h0, 32'h00000040, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000007C, 32'h12345678, 4'hF, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000007C, 32'h0, 4'h0, 32'h12345678, 1'b0};
        vecs[9]  = '{1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[10] = '{1'b1, 32'h00000014, 32'hAABBCCDD, 4'b1000, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 32'h00000014, 32'h0, 4'h0, 32'hAA000050, 1'b0};
        exp_mem[2]  = 32'h00AD00EF;
        exp_mem[5]  = 32'hAA000050;
        exp_mem[31] = 32'h12345678;

        reset = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        a_req_wstrb = '0;   a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_req_wstrb = '0;   b_resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_req_ready", 32'(a_req_ready), 32'd1);
        check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        check("rst_rdata", a_resp_rdata, 32'd0);
        check("rst_error", 32'(a_resp_error), 32'd0);
        for (int i = 0; i < DEPTH; i++) check("rst_mem", a_mem[i], exp_mem[i] & 32'h0 | 32'(i * 16));

        for (int i = 0; i < 12; i++) a_txn(vecs[i], 0);

        // Backpressure: response must stay put while resp_ready is low
        a_txn('{1'b0, 32'h00000004, 32'h0, 4'h0, 32'h00000010, 1'b0}, 5);

        for (int i = 0; i < DEPTH; i++) check("mem_after_table", a_mem[i], exp_mem[i]);

        // Reset in the middle of WAIT discards the pending store
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h0;
        a_req_wdata = 32'hFFFFFFFF; a_req_wstrb = 4'hF;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wait", 32'(a_req_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_resp_valid", 32'(a_resp_valid), 32'd0);
        check("abort_req_ready", 32'(a_req_ready), 32'd1);
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            stray = stray | a_resp_valid;
        end
        check("abort_no_resp", 32'(stray), 32'd0);
        check("abort_mem0", a_mem[0], 32'h0);
        check("abort_mem2_reload", a_mem[2], 32'h00000020);

        // LATENCY=1 instance, back-to-back loads with resp_ready tied high
        @(negedge clk);
        b_req_valid = 1'b1;
        b_req_addr  = 32'h0;
        n = 0; last_acc = 0; acc_cnt = 0; resp_cnt = 0; pending = 1'b0;
        while (resp_cnt < 4 && n < 40) begin
            if (n > 0) @(negedge clk);
            n++;
            if (pending) begin
                pending = 1'b0;
                if (acc_cnt == 4) b_req_valid = 1'b0;
                else b_req_addr = 32'(acc_cnt * 4);
            end
            if (b_resp_valid) begin
                if (sb_b.size() == 0) begin
                    check("b_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb_b.pop_front();
                    check("b_rdata", b_resp_rdata, e.rdata);
                    check("b_error", 32'(b_resp_error), 32'(e.err));
                    check("b_resp_latency", 32'(n - last_acc), 32'd2);
                end
                resp_cnt++;
            end
            if (b_req_valid && b_req_ready) begin
                if (acc_cnt > 0) check("b_accept_spacing", 32'(n - last_acc), 32'd3);
                last_acc = n;
                e.rdata = 32'(acc_cnt * 16);
                e.err   = 1'b0;
                sb_b.push_back(e);
                acc_cnt++;
                pending = 1'b1;
            end
        end
        b_req_valid = 1'b0;
        check("b_resp_count", 32'(resp_cnt), 32'd4);
        check("b_accept_count", 32'(acc_cnt), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
